// File: rtl/shot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shot_sequencer
//  Description : Possession / shot-clock sequencer with BCD scorekeeping.
//  Revision    : 1.0 - initial release
// ============================================================================
module shot_sequencer #(
    parameter int BUZZ_TICKS = 2,
    parameter int FLIGHT_TMO = 4
) (
    input  logic       CLK100MHZ,
    input  logic       rst_n,
    input  logic       start,
    input  logic       tick_1hz,
    input  logic       clk_zero,
    input  logic       shot_fire,
    input  logic       shot_done,
    input  logic       shot_made,
    input  logic       three_pt,
    input  logic       score_clr,
    output logic       clk_load,
    output logic       clk_run,
    output logic       buzzer,
    output logic       violation,
    output logic [3:0] score_s1,
    output logic [3:0] score_s0,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_FLIGHT = 3'd3,
        S_VIOL   = 3'd4
    } state_t;

    // A counter equal to "last" while a tick arrives is the tick that expires it.
    localparam logic [3:0] c_buzz_last   = 4'(BUZZ_TICKS - 1);
    localparam logic [3:0] c_flight_last = 4'(FLIGHT_TMO - 1);

    state_t     r_state;
    logic       r_three_pt;
    logic [3:0] r_flight_cnt;
    logic [3:0] r_buzz_cnt;
    logic [3:0] r_s1;
    logic [3:0] r_s0;

    state_t     w_state_nxt;
    logic       w_fire_accept;
    logic       w_score_add;
    logic [3:0] w_pts;
    logic [3:0] w_units;
    logic [3:0] w_s1_nxt;
    logic [3:0] w_s0_nxt;

    always_comb begin
        w_state_nxt   = r_state;
        w_fire_accept = 1'b0;
        w_score_add   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end else if (shot_fire) begin
                    w_state_nxt   = S_FLIGHT;
                    w_fire_accept = 1'b1;
                end else if (clk_zero) begin
                    w_state_nxt = S_VIOL;
                end
            end
            S_FLIGHT: begin
                if (shot_done) begin
                    if (shot_made) begin
                        w_state_nxt = S_IDLE;
                        w_score_add = 1'b1;
                    end else begin
                        w_state_nxt = S_LOAD;
                    end
                end else if (tick_1hz && (r_flight_cnt == c_flight_last)) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_VIOL: begin
                if (tick_1hz && (r_buzz_cnt == c_buzz_last)) w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Units digit never exceeds 9+3, so 4-bit arithmetic is sufficient.
    always_comb begin
        w_pts   = r_three_pt ? 4'd3 : 4'd2;
        w_units = r_s0 + w_pts;
        if (w_units > 4'd9) begin
            w_s0_nxt = w_units - 4'd10;
            w_s1_nxt = (r_s1 == 4'd9) ? 4'd0 : (r_s1 + 4'd1);
        end else begin
            w_s0_nxt = w_units;
            w_s1_nxt = r_s1;
        end
    end

    always_ff @(posedge CLK100MHZ) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_three_pt   <= 1'b0;
            r_flight_cnt <= 4'd0;
            r_buzz_cnt   <= 4'd0;
            r_s1         <= 4'd0;
            r_s0         <= 4'd0;
            clk_load     <= 1'b0;
            clk_run      <= 1'b0;
            buzzer       <= 1'b0;
            violation    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            clk_load  <= (w_state_nxt == S_LOAD);
            clk_run   <= (w_state_nxt == S_RUN);
            buzzer    <= (w_state_nxt == S_VIOL);
            violation <= (w_state_nxt == S_VIOL);

            if (w_fire_accept) r_three_pt <= three_pt;

            // Counters hold zero outside their state, so they start clean on entry.
            if ((r_state == S_FLIGHT) && (w_state_nxt == S_FLIGHT)) begin
                if (tick_1hz) r_flight_cnt <= r_flight_cnt + 4'd1;
            end else begin
                r_flight_cnt <= 4'd0;
            end

            if ((r_state == S_VIOL) && (w_state_nxt == S_VIOL)) begin
                if (tick_1hz) r_buzz_cnt <= r_buzz_cnt + 4'd1;
            end else begin
                r_buzz_cnt <= 4'd0;
            end

            if ((r_state == S_IDLE) && score_clr) begin
                r_s1 <= 4'd0;
                r_s0 <= 4'd0;
            end else if (w_score_add) begin
                r_s1 <= w_s1_nxt;
                r_s0 <= w_s0_nxt;
            end
        end
    end

    assign state    = r_state;
    assign score_s1 = r_s1;
    assign score_s0 = r_s0;

endmodule
`default_nettype wire

// File: tb/tb_shot_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shot_sequencer
//  Description : Directed self-checking bench for shot_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shot_sequencer;

    localparam int BUZZ_TICKS = 2;
    localparam int FLIGHT_TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n, start, tick_1hz, clk_zero, shot_fire, shot_done;
    logic       shot_made, three_pt, score_clr;
    logic       clk_load, clk_run, buzzer, violation;
    logic [3:0] score_s1, score_s0;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    shot_sequencer #(.BUZZ_TICKS(BUZZ_TICKS), .FLIGHT_TMO(FLIGHT_TMO)) dut (
        .CLK100MHZ(clk), .rst_n(rst_n), .start(start), .tick_1hz(tick_1hz),
        .clk_zero(clk_zero), .shot_fire(shot_fire), .shot_done(shot_done),
        .shot_made(shot_made), .three_pt(three_pt), .score_clr(score_clr),
        .clk_load(clk_load), .clk_run(clk_run), .buzzer(buzzer),
        .violation(violation), .score_s1(score_s1), .score_s0(score_s0),
        .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: mode number, decimal score, and tick tallies.
    int m_mode  = 0;
    int m_score = 0;
    int m_three = 0;
    int m_ft    = 0;
    int m_bt    = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_mode = 0; m_score = 0; m_three = 0; m_ft = 0; m_bt = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (score_clr) m_score = 0;
                    if (start) m_mode = 1;
                end
                1: m_mode = 2;
                2: begin
                    if (start) m_mode = 1;
                    else if (shot_fire) begin m_three = int'(three_pt); m_ft = 0; m_mode = 3; end
                    else if (clk_zero) begin m_bt = 0; m_mode = 4; end
                end
                3: begin
                    if (tick_1hz) m_ft++;
                    if (shot_done) begin
                        if (shot_made) begin
                            m_score = (m_score + (m_three != 0 ? 3 : 2)) % 100;
                            m_mode  = 0;
                        end else m_mode = 1;
                    end else if (m_ft >= FLIGHT_TMO) m_mode = 1;
                end
                4: begin
                    if (tick_1hz) m_bt++;
                    if (m_bt >= BUZZ_TICKS) m_mode = 0;
                end
                default: m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [14:0] act, exp;
            act = {state, clk_load, clk_run, buzzer, violation, score_s1, score_s0};
            exp = {3'(m_mode), m_mode == 1, m_mode == 2, m_mode == 4, m_mode == 4,
                   4'(m_score / 10), 4'(m_score % 10)};
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t actual=%h required=%h", $time, act, exp);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic pulse_tick();
        tick_1hz = 1'b1; cyc(1); tick_1hz = 1'b0;
    endtask

    // From IDLE: start, reach RUN, fire, then resolve with shot_done.
    task automatic shot(input logic tp, input logic made);
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(1);
        shot_fire = 1'b1; three_pt = tp; cyc(1); shot_fire = 1'b0; three_pt = 1'b0;
        shot_done = 1'b1; shot_made = made; cyc(1); shot_done = 1'b0; shot_made = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; tick_1hz = 1'b0; clk_zero = 1'b0; shot_fire = 1'b0;
        shot_done = 1'b0; shot_made = 1'b0; three_pt = 1'b0; score_clr = 1'b0;
        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        chk("reset_state", int'(state), 0);
        chk("reset_score", int'({score_s1, score_s0}), 0);
        rst_n = 1'b1;
        cyc(1);

        // Start sequence.
        start = 1'b1; cyc(1); start = 1'b0;
        chk("load_state", int'(state), 1);
        chk("load_pulse", int'(clk_load), 1);
        cyc(1);
        chk("run_state", int'(state), 2);
        chk("load_drop", int'(clk_load), 0);
        chk("run_en", int'(clk_run), 1);
        cyc(3);

        // Violation with a start during the buzz.
        clk_zero = 1'b1; cyc(1); clk_zero = 1'b0;
        chk("viol_state", int'(state), 4);
        chk("viol_buzz", int'(buzzer), 1);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("viol_ign_start", int'(state), 4);
        pulse_tick(); cyc(2);
        chk("viol_after_1tick", int'(state), 4);
        pulse_tick();
        chk("viol_exit_state", int'(state), 0);
        chk("viol_exit_buzz", int'(buzzer), 0);

        // Made shots: three then two.
        score_clr = 1'b1; cyc(1); score_clr = 1'b0;
        shot(1'b1, 1'b1);
        chk("score_3", int'({score_s1, score_s0}), 8'h03);
        chk("idle_after_made", int'(state), 0);
        shot(1'b0, 1'b1);
        chk("score_5", int'({score_s1, score_s0}), 8'h05);

        // Release beats expiring clock.
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        shot_fire = 1'b1; clk_zero = 1'b1; cyc(1); shot_fire = 1'b0; clk_zero = 1'b0;
        chk("fire_vs_zero", int'(state), 3);
        chk("fire_vs_zero_buzz", int'(buzzer), 0);

        // Missed shot rebounds.
        shot_done = 1'b1; shot_made = 1'b0; cyc(1); shot_done = 1'b0;
        chk("miss_load", int'(state), 1);
        cyc(1);
        chk("miss_run", int'(state), 2);
        chk("miss_score", int'({score_s1, score_s0}), 8'h05);

        // Flight timeout after FLIGHT_TMO ticks.
        shot_fire = 1'b1; cyc(1); shot_fire = 1'b0;
        start = 1'b1; clk_zero = 1'b1; cyc(1); start = 1'b0; clk_zero = 1'b0;
        chk("flight_ignores", int'(state), 3);
        for (int i = 0; i < 3; i++) begin pulse_tick(); cyc(1); end
        chk("flight_3ticks", int'(state), 3);
        pulse_tick();
        chk("flight_tmo", int'(state), 1);
        chk("flight_tmo_score", int'({score_s1, score_s0}), 8'h05);
        cyc(1);

        // Score wrap 98 + 3 -> 01 (back to IDLE via a made shot first).
        shot_fire = 1'b1; cyc(1); shot_fire = 1'b0;
        shot_done = 1'b1; shot_made = 1'b1; cyc(1); shot_done = 1'b0; shot_made = 1'b0;
        score_clr = 1'b1; cyc(1); score_clr = 1'b0;
        chk("clr_score", int'({score_s1, score_s0}), 0);
        for (int i = 0; i < 32; i++) shot(1'b1, 1'b1);
        shot(1'b0, 1'b1);
        chk("score_98", int'({score_s1, score_s0}), 8'h98);
        shot(1'b1, 1'b1);
        chk("score_wrap_01", int'({score_s1, score_s0}), 8'h01);

        // Reset during FLIGHT with a made shot.
        score_clr = 1'b1; cyc(1); score_clr = 1'b0;
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        shot_fire = 1'b1; cyc(1); shot_fire = 1'b0;
        rst_n = 1'b0; shot_done = 1'b1; shot_made = 1'b1; cyc(1);
        rst_n = 1'b1; shot_done = 1'b0; shot_made = 1'b0;
        chk("rst_flight_state", int'(state), 0);
        chk("rst_flight_score", int'({score_s1, score_s0}), 0);

        // Reset during VIOLATION, then IDLE behaviour.
        start = 1'b1; cyc(1); start = 1'b0; cyc(1);
        clk_zero = 1'b1; cyc(1); clk_zero = 1'b0;
        rst_n = 1'b0; cyc(1); rst_n = 1'b1;
        chk("rst_viol_buzz", int'(buzzer), 0);
        shot_fire = 1'b1; shot_done = 1'b1; shot_made = 1'b1; clk_zero = 1'b1; cyc(1);
        shot_fire = 1'b0; shot_done = 1'b0; shot_made = 1'b0; clk_zero = 1'b0;
        chk("idle_ignores", int'(state), 0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("post_rst_start", int'(state), 1);
        cyc(2);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shot_sequencer.md
SHOT_SEQUENCER -- requirements
Module: shot_sequencer

Interface
REQ-001 Parameter BUZZ_TICKS, default 2, number of tick_1hz pulses the buzzer stays on after a violation (range 1..15).
REQ-002 Parameter FLIGHT_TMO, default 4, tick_1hz pulses allowed in FLIGHT before the shot is scored as a miss (range 1..15).
REQ-003 CLK100MHZ  input  1  system clock, 100 MHz; all logic on its rising edge.
REQ-004 rst_n  input  1  reset: synchronous, active-low.
REQ-005 start  input  1  debounced single-cycle pulse; begins or restarts a possession.
REQ-006 tick_1hz  input  1  single-cycle 1 Hz strobe from the clock divider.
REQ-007 clk_zero  input  1  shot-clock counter reads 00.
REQ-008 shot_fire  input  1  single-cycle pulse; ball released.
REQ-009 shot_done  input  1  single-cycle pulse; shot result valid.
REQ-010 shot_made  input  1  result; qualified only by shot_done.
REQ-011 three_pt  input  1  shot value select; sampled only on the accepted shot_fire cycle.
REQ-012 score_clr  input  1  level; clears the score, honoured only in IDLE.
REQ-013 clk_load  output  1  one-cycle load pulse to the shot-clock counter.
REQ-014 clk_run  output  1  countdown enable; the counter decrements only on tick_1hz AND clk_run.
REQ-015 buzzer  output  1  buzzer drive.
REQ-016 violation  output  1  high while in VIOLATION.
REQ-017 score_s1, score_s0  output  4 each  BCD tens and units of the score.
REQ-018 state  output  3  encoded FSM state: IDLE=0, LOAD=1, RUN=2, FLIGHT=3, VIOLATION=4.

Function
REQ-019 All outputs are registered; state transitions take effect on the clock edge after the qualifying input cycle.
REQ-020 IDLE: clk_run=0; start -> LOAD; score_clr=1 -> score 00 on the next edge; shot_fire, shot_done and clk_zero are ignored.
REQ-021 LOAD: clk_load=1 for exactly this one cycle, clk_run=0; unconditional transition to RUN.
REQ-022 RUN: clk_run=1. Priority, highest first: start -> LOAD; shot_fire -> FLIGHT with three_pt latched; clk_zero -> VIOLATION; otherwise remain in RUN.
REQ-023 RUN with shot_fire and clk_zero in the same cycle -> FLIGHT (release beats the buzzer); no violation.
REQ-024 FLIGHT: clk_run=0, so the clock is frozen; flight tick counter is cleared on entry and increments on each tick_1hz.
REQ-025 FLIGHT with shot_done and shot_made=1: add 3 if the latched three_pt=1, else add 2, then -> IDLE.
REQ-026 FLIGHT with shot_done and shot_made=0 -> LOAD (rebound, reloads the clock).
REQ-027 FLIGHT when the flight tick count reaches FLIGHT_TMO without shot_done -> LOAD as a miss, with no score change; shot_done in that same cycle takes priority over the timeout.
REQ-028 FLIGHT ignores start, shot_fire and clk_zero.
REQ-029 VIOLATION: buzzer=1, violation=1, clk_run=0; buzz tick counter is cleared on entry; after BUZZ_TICKS tick_1hz pulses -> IDLE with buzzer=0 on the same edge; start ignored.
REQ-030 Score update is BCD add: units = s0+pts; if units>9 then s0=units-10 and carry into s1.
REQ-031 On carry, s1=9 wraps to 0, so the score wraps 99 -> 00 (e.g. 98+3 = 01); the score never holds a non-BCD digit.
REQ-032 buzzer and violation are 0 in every state other than VIOLATION; clk_load is 0 in every state other than LOAD.
REQ-033 Illegal state encodings (5..7) -> IDLE on the next edge.

Reset
REQ-034 rst_n=0 sampled on a rising edge forces: state=IDLE, clk_load=0, clk_run=0, buzzer=0, violation=0, score 00, latched three_pt=0, both tick counters 0.
REQ-035 Reset dominates every other input, including mid-FLIGHT and mid-VIOLATION; no score update occurs on the reset cycle.
REQ-036 After rst_n returns high, the first edge behaves as IDLE.

Verification
REQ-037 Reset, then start pulse -> state 0->1->2 on consecutive edges; clk_load high for exactly 1 cycle; clk_run=1 from the RUN cycle on.
REQ-038 In RUN, clk_zero=1 -> VIOLATION with buzzer=1; after 2 tick_1hz pulses -> IDLE with buzzer=0; a start during the buzz is ignored.
REQ-039 In RUN, shot_fire with three_pt=1, then shot_done with shot_made=1 -> score 03 and state IDLE; repeat with three_pt=0 -> score 05.
REQ-040 Score 98, made three-pointer -> score 01. Missed shot -> LOAD then RUN with score unchanged. No shot_done for 4 ticks -> LOAD as a miss.
REQ-041 shot_fire and clk_zero in the same RUN cycle -> FLIGHT, buzzer stays 0.
REQ-042 rst_n=0 during FLIGHT in the same cycle as shot_done with shot_made=1 -> IDLE, score unchanged at 00.
